// File: rtl/mz_cmd_issuer.sv
// Command front-end for the mz zero-range memory controller: turns single
// read/write/zero-range commands into mz pin sequences and returns read data.
module mz_cmd_issuer #(
    parameter int ADDRWIDTH = 6,
    parameter int DATAWIDTH = 8,
    parameter int TIMEOUT   = 256
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [ADDRWIDTH-1:0] cmd_addr,
    input  logic [ADDRWIDTH-1:0] cmd_addr_hi,
    input  logic [DATAWIDTH-1:0] cmd_data,
    output logic                 rsp_valid,
    output logic [DATAWIDTH-1:0] rsp_data,
    output logic                 err,
    output logic                 mem_ld_high,
    output logic                 mem_ld_low,
    output logic [ADDRWIDTH-1:0] mem_addr,
    output logic [DATAWIDTH-1:0] mem_din,
    output logic                 mem_write,
    output logic                 mem_zero,
    input  logic [DATAWIDTH-1:0] mem_dout,
    input  logic                 mem_busy
);

    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE, WR1, WR2, RD, RDCAP, LDLO, LDHI, ZGO, ZW1, ZWAIT
    } state_t;

    state_t                 state, next_state;
    logic [ADDRWIDTH-1:0]   lat_addr, lat_hi;
    logic [DATAWIDTH-1:0]   lat_data;
    logic [WDW-1:0]         wd_cnt, wd_next;
    logic                   accept, set_err;
    logic [ADDRWIDTH-1:0]   cur_addr, cur_hi, n_addr;
    logic [DATAWIDTH-1:0]   cur_data, n_din;
    logic                   n_write, n_ld_low, n_ld_high, n_zero;

    assign cmd_ready = (state == IDLE) && !mem_busy && !reset;
    assign accept    = cmd_valid && cmd_ready;

    // Next-state, watchdog and error decisions.
    always_comb begin
        next_state = state;
        wd_next    = wd_cnt;
        set_err    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        2'b00:   next_state = RD;
                        2'b01:   next_state = WR1;
                        2'b10:   next_state = LDLO;
                        default: set_err = 1'b1;
                    endcase
                end else begin
                    next_state = IDLE;
                end
            end
            WR1:   next_state = WR2;
            WR2:   next_state = IDLE;
            RD:    next_state = RDCAP;
            RDCAP: next_state = IDLE;
            LDLO:  next_state = LDHI;
            LDHI:  next_state = ZGO;
            ZGO:   next_state = ZW1;
            ZW1: begin
                next_state = ZWAIT;
                wd_next    = '0;
            end
            ZWAIT: begin
                if (!mem_busy) begin
                    next_state = IDLE;
                end else if (wd_cnt == WD_LAST) begin
                    next_state = IDLE;
                    set_err    = 1'b1;
                end else begin
                    wd_next = wd_cnt + WDW'(1);
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Pin values for the state being entered; the command fields come straight
    // from the inputs on the accepting edge and from the latches afterwards.
    always_comb begin
        cur_addr  = (state == IDLE) ? cmd_addr    : lat_addr;
        cur_hi    = (state == IDLE) ? cmd_addr_hi : lat_hi;
        cur_data  = (state == IDLE) ? cmd_data    : lat_data;
        n_addr    = mem_addr;
        n_din     = mem_din;
        n_write   = 1'b0;
        n_ld_low  = 1'b0;
        n_ld_high = 1'b0;
        n_zero    = 1'b0;
        case (next_state)
            WR1, WR2: begin
                n_write = 1'b1;
                n_addr  = cur_addr;
                n_din   = cur_data;
            end
            RD, RDCAP: n_addr = cur_addr;
            LDLO: begin
                n_addr   = cur_addr;
                n_ld_low = 1'b1;
            end
            LDHI: begin
                n_addr    = cur_hi;
                n_ld_high = 1'b1;
            end
            ZGO:     n_zero = 1'b1;
            default: n_zero = 1'b0;
        endcase
    end

    // State, command latches, watchdog and all registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            lat_addr    <= '0;
            lat_hi      <= '0;
            lat_data    <= '0;
            wd_cnt      <= '0;
            err         <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            mem_addr    <= '0;
            mem_din     <= '0;
            mem_write   <= 1'b0;
            mem_ld_low  <= 1'b0;
            mem_ld_high <= 1'b0;
            mem_zero    <= 1'b0;
        end else begin
            state       <= next_state;
            wd_cnt      <= wd_next;
            mem_addr    <= n_addr;
            mem_din     <= n_din;
            mem_write   <= n_write;
            mem_ld_low  <= n_ld_low;
            mem_ld_high <= n_ld_high;
            mem_zero    <= n_zero;
            rsp_valid   <= (state == RDCAP);
            if (accept) begin
                lat_addr <= cmd_addr;
                lat_hi   <= cmd_addr_hi;
                lat_data <= cmd_data;
            end
            if (set_err) begin
                err <= 1'b1;
            end
            if (state == RDCAP) begin
                rsp_data <= mem_dout;
            end
        end
    end

endmodule

// File: tb/tb_mz_cmd_issuer.sv
// Self-checking bench for mz_cmd_issuer: behavioural mz model, reference memory
// image, directed scenarios plus a randomized command mix.
module tb_mz_cmd_issuer;
    localparam int AW = 6;
    localparam int DW = 8;
    localparam int TO = 256;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'b00;
    logic [AW-1:0] cmd_addr = '0;
    logic [AW-1:0] cmd_addr_hi = '0;
    logic [DW-1:0] cmd_data = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          err;
    logic          mem_ld_high, mem_ld_low, mem_write, mem_zero;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;
    logic          mem_busy;
    logic          mz_busy = 1'b0;
    logic          stub_busy = 1'b0;

    int errors = 0;
    int checks = 0;
    int excl_viol = 0;
    int rsp_count = 0;
    bit keep_valid = 1'b0;

    logic [DW-1:0] mz_mem [0:63];
    logic [DW-1:0] refm   [0:63];
    logic [AW-1:0] mz_lo, mz_hi, mz_ptr;

    assign mem_busy = mz_busy | stub_busy;

    always #5 clock = ~clock;

    mz_cmd_issuer #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_addr_hi(cmd_addr_hi), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .err(err),
        .mem_ld_high(mem_ld_high), .mem_ld_low(mem_ld_low), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_write(mem_write), .mem_zero(mem_zero),
        .mem_dout(mem_dout), .mem_busy(mem_busy)
    );

    // Behavioural mz: registered read, write strobe, one row zeroed per busy cycle.
    always @(posedge clock) begin
        mem_dout <= mz_mem[mem_addr];
        if (mem_ld_low)  mz_lo <= mem_addr;
        if (mem_ld_high) mz_hi <= mem_addr;
        if (mem_write)   mz_mem[mem_addr] <= mem_din;
        if (reset) begin
            mz_busy <= 1'b0;
        end else if (mz_busy) begin
            mz_mem[mz_ptr] <= '0;
            if (mz_ptr == mz_hi) mz_busy <= 1'b0;
            else                 mz_ptr <= mz_ptr + 6'd1;
        end else if (mem_zero) begin
            mz_busy <= 1'b1;
            mz_ptr  <= mz_lo;
        end
    end

    // Strobe exclusivity and response pulse monitor.
    always @(negedge clock) begin
        if ((int'(mem_ld_low) + int'(mem_ld_high) + int'(mem_zero) + int'(mem_write)) > 1)
            excl_viol <= excl_viol + 1;
        if (rsp_valid) rsp_count <= rsp_count + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] hi,
                         input logic [DW-1:0] d);
        int n;
        cmd_op = op; cmd_addr = a; cmd_addr_hi = hi; cmd_data = d; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 2000) begin
            step();
            n++;
        end
        chk("accept_wait", 32'(n < 2000), 32'd1);
        step();
        if (!keep_valid) cmd_valid = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [2:0] wp, rp;
        issue(2'b01, a, '0, d);
        chk("wr_addr", 32'(mem_addr), 32'(a));
        chk("wr_din", 32'(mem_din), 32'(d));
        for (int k = 0; k < 3; k++) begin
            wp[2-k] = mem_write;
            rp[2-k] = cmd_ready;
            if (k < 2) step();
        end
        chk("wr_pulse", 32'(wp), 32'b110);
        chk("wr_ready", 32'(rp), 32'b001);
        refm[a] = d;
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        logic [3:0] vp;
        issue(2'b00, a, '0, '0);
        chk("rd_addr", 32'({mem_write, mem_addr}), 32'(a));
        for (int k = 0; k < 4; k++) begin
            vp[3-k] = rsp_valid;
            if (k == 2) chk("rd_data", 32'(rsp_data), 32'(refm[a]));
            if (k < 3) step();
        end
        chk("rd_valid_pulse", 32'(vp), 32'b0010);
    endtask

    task automatic do_zero(input logic [AW-1:0] lo, input logic [AW-1:0] hi);
        int n, rows;
        logic [AW-1:0] r;
        issue(2'b10, lo, hi, '0);
        chk("z_ldlo", 32'({mem_ld_low, mem_ld_high, mem_zero, mem_write}), 32'b1000);
        chk("z_lo_addr", 32'(mem_addr), 32'(lo));
        step();
        chk("z_ldhi", 32'({mem_ld_low, mem_ld_high, mem_zero, mem_write}), 32'b0100);
        chk("z_hi_addr", 32'(mem_addr), 32'(hi));
        step();
        chk("z_go", 32'({mem_ld_low, mem_ld_high, mem_zero, mem_write}), 32'b0010);
        step();
        chk("z_w1", 32'({mem_ld_low, mem_ld_high, mem_zero, mem_write, cmd_ready}), 32'b00000);
        n = 0;
        while (!cmd_ready && n < 300) begin
            step();
            n++;
        end
        rows = ((int'(hi) - int'(lo) + 64) % 64) + 1;
        chk("z_len", 32'(n), 32'(rows + 1));
        chk("z_err", 32'(err), 32'd0);
        r = lo;
        for (int k = 0; k < 64; k++) begin
            refm[r] = '0;
            if (r == hi) break;
            r = r + 6'd1;
        end
    endtask

    task automatic mem_check(input string tag);
        int bad = 0;
        for (int i = 0; i < 64; i++)
            if (mz_mem[i] !== refm[i]) bad++;
        chk(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        int r0;
        // Reset state
        repeat (2) step();
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        chk("rst_ctl", 32'({mem_ld_high, mem_ld_low, mem_write, mem_zero, rsp_valid, err}), 32'd0);
        chk("rst_bus", 32'({mem_addr, mem_din, rsp_data}), 32'd0);
        reset = 1'b0;
        step();
        chk("idle_ready", 32'(cmd_ready), 32'd1);

        // Back-to-back writes with cmd_valid held
        keep_valid = 1'b1;
        for (int i = 0; i < 64; i++) do_write(AW'(i), DW'(i));
        keep_valid = 1'b0;
        cmd_valid = 1'b0;
        step();
        mem_check("mem_after_writes");

        for (int i = 0; i < 64; i++) do_read(AW'(i));

        do_zero(6'd15, 6'd15);
        mem_check("mem_zero_single");
        do_zero(6'd31, 6'd15);
        mem_check("mem_zero_wrap");

        // Randomized command mix against the reference image
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0:       do_write(AW'($urandom), DW'($urandom));
                1:       do_read(AW'($urandom));
                default: do_zero(AW'($urandom), AW'($urandom));
            endcase
        end
        mem_check("mem_random");

        // Reset during LDHI of a zero-range
        issue(2'b10, 6'd8, 6'd12, '0);
        step();
        chk("ldhi_seen", 32'(mem_ld_high), 32'd1);
        reset = 1'b1;
        step();
        chk("rst_z_strobes", 32'({mem_ld_low, mem_ld_high, mem_zero, mem_write, err}), 32'd0);
        reset = 1'b0;
        step();
        chk("rst_z_ready", 32'(cmd_ready), 32'd1);
        // Reset during RD of a read
        r0 = rsp_count;
        issue(2'b00, 6'd7, '0, '0);
        reset = 1'b1;
        step();
        chk("rst_rd_out", 32'({mem_ld_low, mem_ld_high, mem_zero, mem_write, rsp_valid, err}), 32'd0);
        reset = 1'b0;
        repeat (4) step();
        chk("rst_rd_no_rsp", 32'(rsp_count), 32'(r0));
        chk("rst_rd_ready", 32'(cmd_ready), 32'd1);
        mem_check("mem_after_abort");

        // Reserved op
        chk("err_before_rsv", 32'(err), 32'd0);
        issue(2'b11, 6'd3, 6'd9, 8'h11);
        chk("rsv_strobes", 32'({mem_ld_low, mem_ld_high, mem_zero, mem_write}), 32'd0);
        chk("rsv_err", 32'(err), 32'd1);
        chk("rsv_ready", 32'(cmd_ready), 32'd1);
        do_write(6'd5, 8'hA5);
        do_read(6'd5);
        chk("mem5", 32'(mz_mem[5]), 32'hA5);

        // Zero watchdog with busy stuck high
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("err_cleared", 32'(err), 32'd0);
        issue(2'b10, 6'd0, 6'd3, '0);
        stub_busy = 1'b1;
        step();
        step();
        chk("wd_zero", 32'(mem_zero), 32'd1);
        repeat (TO + 1) step();
        chk("wd_err_early", 32'({err, cmd_ready}), 32'b00);
        step();
        chk("wd_err", 32'(err), 32'd1);
        chk("wd_idle", 32'({mem_ld_low, mem_ld_high, mem_zero, mem_write, cmd_ready}), 32'd0);
        stub_busy = 1'b0;
        step();
        chk("wd_ready", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 4; i++) refm[i] = '0;
        mem_check("mem_final");
        chk("strobe_exclusive", 32'(excl_viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
